// File: rtl/rx_instr_fetch.sv
// Purpose: RandomX program store and instruction sequencer that replays one program N times into the decoder.
// Latency: start accepted at edge T gives first instr_v_o at T+2; branch target valid 2 cycles after the br_v_i cycle.
// Backpressure: valid/ready with a one-entry skid behind the output register, so no loss, no duplicates, full rate on resume.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   prog_wr_*             program RAM write port (accepted in IDLE only)
//   start_i, iter_cnt_i   run request and number of program passes
//   busy_o, done_o        run status (busy in RUN, one-cycle done pulse)
//   iter_o                completed iterations of the current run
//   instr_v_o/instr_o/pc_o/instr_rdy_i   instruction stream to the decoder
//   br_v_i, br_target_i   taken-branch redirect from execute
module rx_instr_fetch #(
    parameter int PROG_LEN = 256,
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 64,
    parameter int ITER_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_wr_v_i,
    input  logic [ADDR_W-1:0]  prog_wr_addr_i,
    input  logic [INSTR_W-1:0] prog_wr_data_i,
    input  logic               start_i,
    input  logic [ITER_W-1:0]  iter_cnt_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [ITER_W-1:0]  iter_o,
    output logic               instr_v_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o,
    input  logic               instr_rdy_i,
    input  logic               br_v_i,
    input  logic [ADDR_W-1:0]  br_target_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic [INSTR_W-1:0] r_mem [PROG_LEN];

    logic [ITER_W-1:0]  r_cnt;
    logic [ITER_W-1:0]  r_iter;
    // Issue side: next pc to read, iteration the issued reads belong to,
    // and a flag set once the final pc of the final pass has been read.
    logic [ADDR_W-1:0]  r_fpc;
    logic [ITER_W-1:0]  r_iss_iter;
    logic               r_iss_stop;
    // RAM read in flight (data appears in r_rd_dat this cycle).
    logic               r_rd_v;
    logic [ADDR_W-1:0]  r_rd_pc;
    logic [INSTR_W-1:0] r_rd_dat;
    // Output register and skid entry.
    logic               r_out_v;
    logic [INSTR_W-1:0] r_out_dat;
    logic [ADDR_W-1:0]  r_out_pc;
    logic               r_sk_v;
    logic [INSTR_W-1:0] r_sk_dat;
    logic [ADDR_W-1:0]  r_sk_pc;

    logic               w_run;
    logic               w_start;
    logic               w_we;
    logic               w_xfer;
    logic               w_br;
    logic               w_iter_inc;
    logic [ITER_W-1:0]  w_iter_nxt;
    logic               w_final;
    logic [1:0]         w_occ;
    logic               w_issue;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [ITER_W-1:0]  w_iss_base;
    logic               w_iss_last;

    assign w_run      = (r_state == S_RUN);
    assign w_start    = (r_state == S_IDLE) && start_i && (iter_cnt_i != '0);
    assign w_we       = (r_state == S_IDLE) && prog_wr_v_i;
    assign w_xfer     = r_out_v && instr_rdy_i;
    assign w_br       = w_run && br_v_i;
    // A branching transfer never counts as iteration completion.
    assign w_iter_inc = w_xfer && !w_br && (r_out_pc == LAST_PC);
    assign w_iter_nxt = r_iter + ITER_W'(1);
    assign w_final    = w_iter_inc && (w_iter_nxt == r_cnt);

    // Entries held after this edge (output + skid + arriving read). A new
    // read may only be issued if it is guaranteed a slot even if the
    // decoder stalls next cycle, i.e. occupancy after this edge <= 1.
    assign w_occ = {1'b0, r_out_v} + {1'b0, r_sk_v} + {1'b0, r_rd_v} - {1'b0, w_xfer};

    // A branch flushes everything and reads the target immediately.
    assign w_rd_addr  = w_br ? br_target_i : r_fpc;
    // After a flush, the issued stream restarts in the committed iteration.
    assign w_iss_base = w_br ? r_iter : r_iss_iter;
    assign w_iss_last = (w_rd_addr == LAST_PC) && (w_iss_base == r_cnt - ITER_W'(1));
    assign w_issue    = w_br || (w_run && !r_iss_stop && !w_final && (w_occ <= 2'd1));

    // Program RAM: synchronous read, not affected by reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[prog_wr_addr_i] <= prog_wr_data_i;
        end
        r_rd_dat <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_final) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_iter     <= '0;
            r_fpc      <= '0;
            r_iss_iter <= '0;
            r_iss_stop <= 1'b0;
            r_rd_v     <= 1'b0;
            r_rd_pc    <= '0;
            r_out_v    <= 1'b0;
            r_out_dat  <= '0;
            r_out_pc   <= '0;
            r_sk_v     <= 1'b0;
            r_sk_dat   <= '0;
            r_sk_pc    <= '0;
        end else if (w_start) begin
            r_cnt      <= iter_cnt_i;
            r_iter     <= '0;
            r_fpc      <= '0;
            r_iss_iter <= '0;
            r_iss_stop <= 1'b0;
            r_rd_v     <= 1'b0;
            r_out_v    <= 1'b0;
            r_sk_v     <= 1'b0;
        end else if (w_run) begin
            if (w_iter_inc) begin
                r_iter <= w_iter_nxt;
            end

            r_rd_v <= w_issue;
            if (w_issue) begin
                r_rd_pc    <= w_rd_addr;
                r_fpc      <= w_rd_addr + ADDR_W'(1);
                r_iss_stop <= w_iss_last;
                r_iss_iter <= ((w_rd_addr == LAST_PC) && !w_iss_last) ?
                              w_iss_base + ITER_W'(1) : w_iss_base;
            end

            if (w_br || w_final) begin
                r_out_v <= 1'b0;
                r_sk_v  <= 1'b0;
            end else if (w_xfer) begin
                if (r_sk_v) begin
                    r_out_dat <= r_sk_dat;
                    r_out_pc  <= r_sk_pc;
                    r_sk_v    <= r_rd_v;
                    if (r_rd_v) begin
                        r_sk_dat <= r_rd_dat;
                        r_sk_pc  <= r_rd_pc;
                    end
                end else begin
                    r_out_v <= r_rd_v;
                    if (r_rd_v) begin
                        r_out_dat <= r_rd_dat;
                        r_out_pc  <= r_rd_pc;
                    end
                end
            end else if (!r_out_v) begin
                r_out_v <= r_rd_v;
                if (r_rd_v) begin
                    r_out_dat <= r_rd_dat;
                    r_out_pc  <= r_rd_pc;
                end
            end else if (r_rd_v) begin
                // Stalled with a read landing: park it in the skid.
                r_sk_v   <= 1'b1;
                r_sk_dat <= r_rd_dat;
                r_sk_pc  <= r_rd_pc;
            end
        end
    end

    assign busy_o    = (r_state == S_RUN);
    assign done_o    = (r_state == S_DONE);
    assign iter_o    = r_iter;
    assign instr_v_o = r_out_v;
    assign instr_o   = r_out_dat;
    assign pc_o      = r_out_pc;

endmodule

// File: tb/tb_rx_instr_fetch.sv
module tb_rx_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_wr_v_i;
    logic [7:0]  prog_wr_addr_i;
    logic [63:0] prog_wr_data_i;
    logic        start_i;
    logic [11:0] iter_cnt_i;
    logic        busy_o;
    logic        done_o;
    logic [11:0] iter_o;
    logic        instr_v_o;
    logic [63:0] instr_o;
    logic [7:0]  pc_o;
    logic        instr_rdy_i;
    logic        br_v_i;
    logic [7:0]  br_target_i;

    always #5 clk = ~clk;

    rx_instr_fetch #(
        .PROG_LEN(256), .ADDR_W(8), .INSTR_W(64), .ITER_W(12)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .prog_wr_v_i    (prog_wr_v_i),
        .prog_wr_addr_i (prog_wr_addr_i),
        .prog_wr_data_i (prog_wr_data_i),
        .start_i        (start_i),
        .iter_cnt_i     (iter_cnt_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .iter_o         (iter_o),
        .instr_v_o      (instr_v_o),
        .instr_o        (instr_o),
        .pc_o           (pc_o),
        .instr_rdy_i    (instr_rdy_i),
        .br_v_i         (br_v_i),
        .br_target_i    (br_target_i)
    );

    typedef struct {
        logic [11:0] cnt;
        int          rdy_pct;
        bit          use_br;
        logic [7:0]  br_pc;
        logic [7:0]  br_tgt;
        bit          junk_wr;
        int          exp_xfers;
    } scn_t;

    logic [63:0] prog [256];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [11:0] cnt);
        start_i    = 1'b1;
        iter_cnt_i = cnt;
        tick();
        start_i    = 1'b0;
    endtask

    // Runs one complete program run against a reference pc/iteration model.
    task automatic run_scn(input string tag, input scn_t s);
        int          cyc, xfers, ord_errs, stall_errs, iter_errs, busy_errs;
        int          first_v, br_cyc, br_gap, done_cyc, last_xfer;
        bit          done_seen, br_done, prev_stall, rdy, br, v_in_done;
        logic [7:0]  model_pc, prev_pc;
        logic [11:0] model_iter;
        logic [63:0] prev_instr;
        cyc = 0; xfers = 0; ord_errs = 0; stall_errs = 0; iter_errs = 0; busy_errs = 0;
        first_v = -1; br_cyc = -1; br_gap = -1; done_cyc = -1; last_xfer = -100;
        done_seen = 0; br_done = 0; prev_stall = 0; v_in_done = 0;
        model_pc = 8'd0; model_iter = 12'd0; prev_pc = 8'd0; prev_instr = 64'd0;

        do_start(s.cnt);
        while (cyc < 5000 && !done_seen) begin
            if (iter_o !== model_iter) iter_errs++;
            if (done_o === 1'b1) begin
                done_seen = 1;
                done_cyc  = cyc;
                v_in_done = instr_v_o;
                break;
            end
            if (busy_o !== 1'b1) busy_errs++;
            if (instr_v_o === 1'b1 && first_v < 0) first_v = cyc;
            if (br_cyc >= 0 && br_gap < 0 && instr_v_o === 1'b1) br_gap = cyc - br_cyc;
            if (prev_stall && (instr_v_o !== 1'b1 || instr_o !== prev_instr || pc_o !== prev_pc))
                stall_errs++;

            rdy = ($urandom_range(99) < s.rdy_pct);
            br  = 0;
            if (instr_v_o === 1'b1 && rdy) begin
                xfers++;
                last_xfer = cyc;
                if (pc_o !== model_pc || instr_o !== prog[model_pc]) ord_errs++;
                if (s.use_br && !br_done && pc_o == s.br_pc) begin
                    br       = 1;
                    br_done  = 1;
                    br_cyc   = cyc;
                    model_pc = s.br_tgt;
                end else begin
                    if (model_pc == 8'hFF) model_iter++;
                    model_pc = model_pc + 8'd1;
                end
            end
            prev_stall = (instr_v_o === 1'b1) && !rdy;
            prev_instr = instr_o;
            prev_pc    = pc_o;

            instr_rdy_i = rdy;
            br_v_i      = br;
            br_target_i = s.br_tgt;
            if (s.junk_wr && cyc == 20) begin
                prog_wr_v_i    = 1'b1;
                prog_wr_addr_i = 8'd5;
                prog_wr_data_i = 64'hDEAD_BEEF_0BAD_F00D;
            end else begin
                prog_wr_v_i    = 1'b0;
            end
            tick();
            cyc++;
        end
        instr_rdy_i = 1'b1;
        br_v_i      = 1'b0;
        prog_wr_v_i = 1'b0;

        check({tag, "_done_seen"},   64'(done_seen), 64'd1);
        check({tag, "_xfers"},       64'(xfers), 64'(s.exp_xfers));
        check({tag, "_order_errs"},  64'(ord_errs), 64'd0);
        check({tag, "_stall_errs"},  64'(stall_errs), 64'd0);
        check({tag, "_iter_errs"},   64'(iter_errs), 64'd0);
        check({tag, "_busy_errs"},   64'(busy_errs), 64'd0);
        check({tag, "_first_valid"}, 64'(first_v), 64'd2);
        check({tag, "_done_timing"}, 64'(done_cyc - last_xfer), 64'd1);
        check({tag, "_v_in_done"},   64'(v_in_done), 64'd0);
        if (s.use_br) check({tag, "_br_gap"}, 64'(br_gap), 64'd2);
        tick();
        check({tag, "_busy_after"},  64'(busy_o), 64'd0);
        check({tag, "_done_after"},  64'(done_o), 64'd0);
        check({tag, "_iter_final"},  64'(iter_o), 64'(s.cnt));
    endtask

    initial begin
        scn_t tbl [7];
        int   nv, nb, nd, found;

        tbl[0] = '{cnt: 12'd1, rdy_pct: 100, use_br: 0, br_pc: 8'h00, br_tgt: 8'h00, junk_wr: 0, exp_xfers: 256};
        tbl[1] = '{cnt: 12'd3, rdy_pct: 50,  use_br: 0, br_pc: 8'h00, br_tgt: 8'h00, junk_wr: 0, exp_xfers: 768};
        tbl[2] = '{cnt: 12'd1, rdy_pct: 100, use_br: 1, br_pc: 8'h40, br_tgt: 8'h10, junk_wr: 0, exp_xfers: 305};
        tbl[3] = '{cnt: 12'd1, rdy_pct: 100, use_br: 1, br_pc: 8'hFF, br_tgt: 8'hF0, junk_wr: 0, exp_xfers: 272};
        tbl[4] = '{cnt: 12'd2, rdy_pct: 50,  use_br: 1, br_pc: 8'h40, br_tgt: 8'h10, junk_wr: 0, exp_xfers: 561};
        tbl[5] = '{cnt: 12'd1, rdy_pct: 70,  use_br: 1, br_pc: 8'h80, br_tgt: 8'hC0, junk_wr: 0, exp_xfers: 193};
        tbl[6] = '{cnt: 12'd2, rdy_pct: 100, use_br: 0, br_pc: 8'h00, br_tgt: 8'h00, junk_wr: 1, exp_xfers: 512};

        rst = 1'b1; prog_wr_v_i = 1'b0; prog_wr_addr_i = 8'd0; prog_wr_data_i = 64'd0;
        start_i = 1'b0; iter_cnt_i = 12'd0; instr_rdy_i = 1'b1; br_v_i = 1'b0; br_target_i = 8'd0;
        tick(); tick();
        rst = 1'b0;

        check("rst_busy",  64'(busy_o), 64'd0);
        check("rst_done",  64'(done_o), 64'd0);
        check("rst_iter",  64'(iter_o), 64'd0);
        check("rst_v",     64'(instr_v_o), 64'd0);
        check("rst_instr", instr_o, 64'd0);
        check("rst_pc",    64'(pc_o), 64'd0);

        for (int i = 0; i < 256; i++) begin
            prog[i]        = {32'(i), 32'(i * 3)};
            prog_wr_v_i    = 1'b1;
            prog_wr_addr_i = 8'(i);
            prog_wr_data_i = prog[i];
            tick();
        end
        prog_wr_v_i = 1'b0;
        tick();

        for (int k = 0; k < 7; k++) run_scn($sformatf("s%0d", k), tbl[k]);

        // start with a zero count is ignored
        do_start(12'd0);
        nv = 0; nb = 0;
        for (int c = 0; c < 8; c++) begin
            if (instr_v_o !== 1'b0) nv++;
            if (busy_o !== 1'b0) nb++;
            tick();
        end
        check("zero_cnt_busy", 64'(nb), 64'd0);
        check("zero_cnt_v",    64'(nv), 64'd0);

        // reset in the middle of the second pass at pc 0x80
        instr_rdy_i = 1'b1;
        do_start(12'd2);
        found = 0;
        for (int c = 0; c < 700 && found == 0; c++) begin
            if (instr_v_o === 1'b1 && pc_o == 8'h80 && iter_o == 12'd1) found = 1;
            else tick();
        end
        check("midrst_reached", 64'(found), 64'd1);
        rst = 1'b1;
        tick();
        check("midrst_v",    64'(instr_v_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_iter", 64'(iter_o), 64'd0);
        check("midrst_done", 64'(done_o), 64'd0);
        rst = 1'b0;
        nd = 0; nv = 0;
        for (int c = 0; c < 6; c++) begin
            if (done_o !== 1'b0) nd++;
            if (instr_v_o !== 1'b0) nv++;
            tick();
        end
        check("midrst_no_done", 64'(nd), 64'd0);
        check("midrst_no_v",    64'(nv), 64'd0);

        // restart replays the intact program
        run_scn("restart", tbl[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
